neighbor_fetch_2x: RTL

Upstream stage of the cartoon/edge filter path. It reads the 320x240 RGB565 frame buffer through a single synchronous read port while the VGA timing generator scans 640x480 with 2x pixel doubling. For every VGA pixel it presents the source pixel, its right neighbour and its down neighbour as RGB444 triples. Delayed DE and syncs are output alongside, so the filter and the DAC see everything aligned.

---
 rtl/neighbor_fetch_2x_if.sv | 41 ++++
 rtl/neighbor_fetch_2x.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/neighbor_fetch_2x_if.sv
// neighbor_fetch_2x_if
//   Bundles the timing-generator inputs, the frame-buffer read port and the
//   aligned colour/sync outputs of neighbor_fetch_2x.
//   slave  : the fetch block (consumes timing + rData, drives rAddr + outputs)
//   master : the surrounding system (timing generator, frame buffer, filter)
//   Signals:
//     DE, h_sync, v_sync      timing generator display enable and syncs
//     x_pixel, y_pixel        VGA coordinates (0..639, 0..479)
//     rAddr                   frame-buffer read address (combinational)
//     rData                   RGB565 read data, valid one cycle after rAddr
//     r_c/g_c/b_c             centre pixel, RGB444
//     r_r/g_r/b_r             right neighbour, RGB444
//     r_d/g_d/b_d             down neighbour, RGB444
//     de_out, hs_out, vs_out  DE/syncs delayed to match the colour outputs
interface neighbor_fetch_2x_if;
    logic        DE;
    logic        h_sync;
    logic        v_sync;
    logic [9:0]  x_pixel;
    logic [9:0]  y_pixel;
    logic [16:0] rAddr;
    logic [15:0] rData;
    logic [3:0]  r_c, g_c, b_c;
    logic [3:0]  r_r, g_r, b_r;
    logic [3:0]  r_d, g_d, b_d;
    logic        de_out, hs_out, vs_out;

    modport master (
        output DE, h_sync, v_sync, x_pixel, y_pixel, rData,
        input  rAddr,
        input  r_c, g_c, b_c, r_r, g_r, b_r, r_d, g_d, b_d,
        input  de_out, hs_out, vs_out
    );

    modport slave (
        input  DE, h_sync, v_sync, x_pixel, y_pixel, rData,
        output rAddr,
        output r_c, g_c, b_c, r_r, g_r, b_r, r_d, g_d, b_d,
        output de_out, hs_out, vs_out
    );
endinterface

// File: rtl/neighbor_fetch_2x.sv
// neighbor_fetch_2x
//   Reads a SRC_W x SRC_H RGB565 frame buffer through one synchronous read
//   port while a 640x480 VGA scan runs with 2x pixel doubling. Each source
//   pixel pair gets two fetches (centre on even x, down on odd x); the next
//   pair's centre fetch doubles as the right neighbour. Colour outputs are
//   RGB444 and appear LAT cycles after the VGA pixel, aligned with the
//   delayed DE/syncs.
//   Ports:
//     clk    VGA pixel clock
//     reset  asynchronous, active-high
//     nf     neighbor_fetch_2x_if.slave (timing in, read port, outputs)
module neighbor_fetch_2x #(
    parameter int SRC_W = 320,
    parameter int SRC_H = 240,
    parameter int LAT   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    neighbor_fetch_2x_if.slave     nf
);

    typedef enum logic {
        PH_CENTER = 1'b0,
        PH_DOWN   = 1'b1
    } phase_e;

    // ---------------------------------------------------------------
    // Fetch address
    // ---------------------------------------------------------------
    logic [8:0]  sx, sy, sy_dn, sel_row;
    phase_e      fetch_ph;
    logic [16:0] rd_addr;
    logic        fetch_last;

    always_comb begin
        sx         = nf.x_pixel[9:1];
        sy         = nf.y_pixel[9:1];
        sy_dn      = (sy == 9'(SRC_H - 1)) ? sy : sy + 9'd1;
        fetch_ph   = nf.x_pixel[0] ? PH_DOWN : PH_CENTER;
        sel_row    = (fetch_ph == PH_DOWN) ? sy_dn : sy;
        fetch_last = (sx == 9'(SRC_W - 1));
        rd_addr    = '0;
        if (nf.DE) begin
            rd_addr = 17'(sel_row) * 17'(SRC_W) + 17'(sx);
        end
    end

    assign nf.rAddr = rd_addr;

    // ---------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------
    logic [LAT-1:0] de_q, de_d;
    logic [LAT-1:0] hs_q, hs_d;
    logic [LAT-1:0] vs_q, vs_d;
    phase_e         ph1_q, ph2_q, ph3_q;
    logic           lastf_q;
    logic [11:0]    cap_c_q, cap_c_d;
    logic [11:0]    cap_d_q, cap_d_d;
    logic           last_col_q, last_col_d;
    logic [11:0]    c_q, c_d;
    logic [11:0]    rt_q, rt_d;
    logic [11:0]    dn_q, dn_d;

    logic [11:0]    pix;
    logic           commit_mid, commit_edge;

    function automatic logic [11:0] rgb444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    always_comb begin
        pix  = rgb444(nf.rData);
        de_d = {de_q[LAT-2:0], nf.DE};
        hs_d = {hs_q[LAT-2:0], nf.h_sync};
        vs_d = {vs_q[LAT-2:0], nf.v_sync};

        cap_c_d    = cap_c_q;
        cap_d_d    = cap_d_q;
        last_col_d = last_col_q;
        if (de_q[0] && ph1_q == PH_CENTER) begin
            cap_c_d    = pix;
            last_col_d = lastf_q;
        end
        if (de_q[0] && ph1_q == PH_DOWN) begin
            cap_d_d = pix;
        end

        // Normal commit: rData now holds the next column's centre.
        // Edge commit: the last column has no next fetch (DE already low),
        // so it fires three cycles after its centre fetch and replicates
        // the centre into the right neighbour.
        commit_mid  = de_q[0] && (ph1_q == PH_CENTER);
        commit_edge = de_q[2] && (ph3_q == PH_CENTER) && last_col_q;

        c_d  = c_q;
        rt_d = rt_q;
        dn_d = dn_q;
        if (commit_mid || commit_edge) begin
            c_d  = cap_c_q;
            dn_d = cap_d_q;
            rt_d = commit_edge ? cap_c_q : pix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_q       <= '0;
            hs_q       <= '0;
            vs_q       <= '0;
            ph1_q      <= PH_CENTER;
            ph2_q      <= PH_CENTER;
            ph3_q      <= PH_CENTER;
            lastf_q    <= 1'b0;
            cap_c_q    <= '0;
            cap_d_q    <= '0;
            last_col_q <= 1'b0;
            c_q        <= '0;
            rt_q       <= '0;
            dn_q       <= '0;
        end else begin
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            ph1_q      <= fetch_ph;
            ph2_q      <= ph1_q;
            ph3_q      <= ph2_q;
            lastf_q    <= fetch_last;
            cap_c_q    <= cap_c_d;
            cap_d_q    <= cap_d_d;
            last_col_q <= last_col_d;
            c_q        <= c_d;
            rt_q       <= rt_d;
            dn_q       <= dn_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs: colours forced to zero outside the delayed display window
    // ---------------------------------------------------------------
    logic de_o;
    assign de_o      = de_q[LAT-1];
    assign nf.de_out = de_o;
    assign nf.hs_out = hs_q[LAT-1];
    assign nf.vs_out = vs_q[LAT-1];

    assign nf.r_c = de_o ? c_q[11:8]  : '0;
    assign nf.g_c = de_o ? c_q[7:4]   : '0;
    assign nf.b_c = de_o ? c_q[3:0]   : '0;
    assign nf.r_r = de_o ? rt_q[11:8] : '0;
    assign nf.g_r = de_o ? rt_q[7:4]  : '0;
    assign nf.b_r = de_o ? rt_q[3:0]  : '0;
    assign nf.r_d = de_o ? dn_q[11:8] : '0;
    assign nf.g_d = de_o ? dn_q[7:4]  : '0;
    assign nf.b_d = de_o ? dn_q[3:0]  : '0;

    // Bits dropped by the 2x scaling and the RGB565 -> RGB444 truncation.
    logic unused_bits;
    assign unused_bits = ^{nf.y_pixel[0], nf.rData[11], nf.rData[6:5], nf.rData[0]};

endmodule
